// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use, HI/LO busy and cache-miss stalls, branch flushes.
// Stall/flush outputs are combinational; the mult/div busy count and a pending fetch flush are the only state.
module hazard_ctrl #(
   parameter int MULDIV_LAT = 32,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       id_muldiv_start,
   input  logic       id_hilo_read,
   input  logic [4:0] ex_dst,
   input  logic       ex_rw,
   input  logic       ex_memread,
   input  logic       ex_branch_taken,
   input  logic       icache_ready,
   input  logic       dcache_ready,
   output logic       stall_if,
   output logic       stall_id,
   output logic       stall_ex,
   output logic       stall_mem,
   output logic       bubble_ex,
   output logic       flush_id,
   output logic       muldiv_busy
);

   logic [CNT_W-1:0] r_busy_cnt;
   logic             r_flush_pend;

   logic w_busy;
   logic w_load_use;
   logic w_hilo_hz;
   logic w_dmiss;
   logic w_imiss;
   logic w_flush_pend_nxt;
   logic w_issue;

   assign w_busy     = (r_busy_cnt != '0);
   assign w_load_use = ex_memread & ex_rw & (ex_dst != 5'd0) &
                       ((id_use_rs & (ex_dst == id_rs)) | (id_use_rt & (ex_dst == id_rt)));
   assign w_hilo_hz  = w_busy & (id_hilo_read | id_muldiv_start);
   assign w_dmiss    = ~dcache_ready;
   assign w_imiss    = ~icache_ready;

   always_comb begin
      stall_if         = 1'b0;
      stall_id         = 1'b0;
      stall_ex         = 1'b0;
      stall_mem        = 1'b0;
      bubble_ex        = 1'b0;
      flush_id         = 1'b0;
      w_flush_pend_nxt = r_flush_pend;
      if (reset) begin
         w_flush_pend_nxt = 1'b0;
      end else if (w_dmiss) begin
         // Whole pipe frozen; remember a taken branch so fetch is flushed once the freeze lifts.
         stall_if         = 1'b1;
         stall_id         = 1'b1;
         stall_ex         = 1'b1;
         stall_mem        = 1'b1;
         w_flush_pend_nxt = r_flush_pend | ex_branch_taken;
      end else if (ex_branch_taken | r_flush_pend) begin
         flush_id = 1'b1;
         if (w_imiss) begin
            stall_if         = 1'b1;
            w_flush_pend_nxt = 1'b1;
         end else begin
            w_flush_pend_nxt = 1'b0;
         end
      end else if (w_load_use | w_hilo_hz) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         bubble_ex = 1'b1;
      end else if (w_imiss) begin
         stall_if = 1'b1;
         flush_id = 1'b1;
      end
   end

   assign muldiv_busy = w_busy & ~reset;
   assign w_issue     = id_muldiv_start & ~w_busy & ~stall_id & ~flush_id;

   // The mult/div unit runs on its own, so the count keeps falling through a D-cache freeze.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy_cnt   <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         r_flush_pend <= w_flush_pend_nxt;
         if (w_issue)
            r_busy_cnt <= CNT_W'(MULDIV_LAT);
         else if (w_busy)
            r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MULDIV_LAT=4; expected output vectors go through a scoreboard queue.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_dst;
   logic       id_use_rs, id_use_rt, id_muldiv_start, id_hilo_read;
   logic       ex_rw, ex_memread, ex_branch_taken, icache_ready, dcache_ready;
   logic       stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_id, muldiv_busy;

   hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(6)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_muldiv_start(id_muldiv_start), .id_hilo_read(id_hilo_read),
      .ex_dst(ex_dst), .ex_rw(ex_rw), .ex_memread(ex_memread),
      .ex_branch_taken(ex_branch_taken), .icache_ready(icache_ready),
      .dcache_ready(dcache_ready),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
      .bubble_ex(bubble_ex), .flush_id(flush_id), .muldiv_busy(muldiv_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] v;
      string      name;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // vector order: stall_if stall_id stall_ex stall_mem bubble_ex flush_id muldiv_busy
   localparam logic [6:0] NONE  = 7'b0000000;
   localparam logic [6:0] LU    = 7'b1100100;
   localparam logic [6:0] LUB   = 7'b1100101;
   localparam logic [6:0] FRZ   = 7'b1111000;
   localparam logic [6:0] IMISS = 7'b1000010;
   localparam logic [6:0] FL    = 7'b0000010;

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t       e;
         logic [6:0] act;
         e   = q.pop_front();
         act = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_id, muldiv_busy};
         n_checks++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, act, e.v);
         end
      end
   end

   task automatic defaults();
      reset = 1'b0; id_rs = '0; id_rt = '0; ex_dst = '0;
      id_use_rs = 1'b0; id_use_rt = 1'b0; id_muldiv_start = 1'b0; id_hilo_read = 1'b0;
      ex_rw = 1'b0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
      icache_ready = 1'b1; dcache_ready = 1'b1;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
      defaults();
   endtask

   task automatic expect_v(input logic [6:0] v, input string name);
      exp_t e;
      e.v    = v;
      e.name = name;
      q.push_back(e);
   endtask

   task automatic set_load_use(input logic [4:0] dst);
      ex_memread = 1'b1; ex_rw = 1'b1; ex_dst = dst; id_rs = dst; id_use_rs = 1'b1;
   endtask

   initial begin
      defaults();
      reset = 1'b1;
      repeat (2) @(posedge clk);

      nxt(); reset = 1'b1; dcache_ready = 1'b0; set_load_use(5'd5);
      expect_v(NONE, "reset_outputs");
      nxt(); expect_v(NONE, "idle");

      // load-use on rs, then released once the load leaves EX
      nxt(); set_load_use(5'd5); expect_v(LU, "load_use_rs");
      nxt(); id_rs = 5'd5; id_use_rs = 1'b1; expect_v(NONE, "load_use_done");
      nxt(); ex_memread = 1'b1; ex_rw = 1'b1; ex_dst = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
      expect_v(LU, "load_use_rt");
      nxt(); ex_memread = 1'b1; ex_rw = 1'b1; ex_dst = 5'd7; id_rt = 5'd7;
      expect_v(NONE, "rt_not_used");
      nxt(); set_load_use(5'd0); expect_v(NONE, "reg0_no_hazard");

      // mult then mflo held in ID for the busy window
      nxt(); id_muldiv_start = 1'b1; expect_v(NONE, "mult_issue");
      for (int i = 1; i <= 4; i++) begin
         nxt(); id_hilo_read = 1'b1; expect_v(LUB, $sformatf("mflo_wait_%0d", i));
      end
      nxt(); id_hilo_read = 1'b1; expect_v(NONE, "mflo_proceeds");

      // D-cache freeze hides load-use; the load-use stall follows
      for (int i = 0; i < 3; i++) begin
         nxt(); dcache_ready = 1'b0; set_load_use(5'd9); expect_v(FRZ, $sformatf("dmiss_%0d", i));
      end
      nxt(); set_load_use(5'd9); expect_v(LU, "load_use_after_dmiss");
      nxt(); expect_v(NONE, "after_dmiss_idle");

      // a mult cannot issue while frozen
      nxt(); dcache_ready = 1'b0; id_muldiv_start = 1'b1; expect_v(FRZ, "mult_blocked_dmiss");
      nxt(); expect_v(NONE, "no_busy_after_block");

      // branch during freeze is remembered
      nxt(); dcache_ready = 1'b0; ex_branch_taken = 1'b1; expect_v(FRZ, "branch_in_dmiss");
      nxt(); expect_v(FL, "pending_flush_after_dmiss");
      nxt(); expect_v(NONE, "pend_cleared");

      // branch during I-miss
      for (int i = 0; i < 2; i++) begin
         nxt(); ex_branch_taken = 1'b1; icache_ready = 1'b0; expect_v(IMISS, $sformatf("branch_imiss_%0d", i));
      end
      nxt(); expect_v(FL, "flush_on_fetch_return");
      nxt(); expect_v(NONE, "after_branch_flush");
      nxt(); icache_ready = 1'b0; expect_v(IMISS, "plain_imiss");
      nxt(); expect_v(NONE, "imiss_no_pend");

      // branch beats hilo hazard, then reset mid-operation with busy_cnt=2 and flush pending
      nxt(); id_muldiv_start = 1'b1; expect_v(NONE, "mult_issue2");
      nxt(); ex_branch_taken = 1'b1; id_hilo_read = 1'b1; expect_v(7'b0000011, "branch_over_hilo");
      nxt(); ex_branch_taken = 1'b1; icache_ready = 1'b0; expect_v(7'b1000011, "branch_imiss_busy");
      nxt(); reset = 1'b1; icache_ready = 1'b0; expect_v(NONE, "reset_mid_op");
      nxt(); expect_v(NONE, "after_reset_clear");
      nxt(); id_hilo_read = 1'b1; expect_v(NONE, "after_reset_hilo");

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
